// File: rtl/ray_block_nearest_hit.sv
// ray_block_nearest_hit: streams axis-aligned cubes against one ray and reports the nearest slab-test hit.
// Float ops flush denormals to zero and round to nearest even; the slab result is delayed to a fixed SLAB_LAT.
module ray_block_nearest_hit #(
    parameter logic [31:0] BLOCK_HALF = 32'h42C80000,
    parameter int IDX_W = 8,
    parameter int SLAB_LAT = 40
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [31:0]      eye_x,
    input  logic [31:0]      eye_y,
    input  logic [31:0]      eye_z,
    input  logic [31:0]      ray_x,
    input  logic [31:0]      ray_y,
    input  logic [31:0]      ray_z,
    input  logic             ray_valid_in,
    output logic             ray_ready_out,
    input  logic [31:0]      block_pos_x,
    input  logic [31:0]      block_pos_y,
    input  logic [31:0]      block_pos_z,
    input  logic             block_valid_in,
    input  logic             block_last_in,
    output logic             block_ready_out,
    output logic             hit_out,
    output logic [31:0]      t_out,
    output logic [IDX_W-1:0] hit_idx_out,
    output logic             overflow_out,
    output logic             valid_out
);
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;
    localparam int CW = $clog2(SLAB_LAT + 2);

    function automatic logic [31:0] key(input logic [31:0] x);
        return (x[30:0] == 31'd0) ? 32'h8000_0000 : x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

    function automatic logic flt(input logic [31:0] a, input logic [31:0] b);
        return key(a) < key(b);
    endfunction

    function automatic logic [31:0] fmin(input logic [31:0] a, input logic [31:0] b);
        return flt(a, b) ? a : b;
    endfunction

    function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
        return flt(a, b) ? b : a;
    endfunction

    function automatic logic [31:0] fpack(input logic s, input logic signed [10:0] e,
                                          input logic [22:0] m, input logic g, input logic st);
        logic [23:0] r;
        logic signed [10:0] ee;
        r = {1'b0, m} + {23'd0, g & (st | m[0])};
        ee = e + $signed({10'd0, r[23]});
        if (ee >= 11'sd255) return {s, 8'hFF, 23'd0};
        if (ee <= 11'sd0) return {s, 31'd0};
        return {s, ee[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0] d;
        logic [49:0] bx, bs, n;
        logic [50:0] xm, s;
        logic [5:0] lz;
        logic signed [10:0] e;
        x = (a[30:0] >= b[30:0]) ? a : b;
        y = (a[30:0] >= b[30:0]) ? b : a;
        if (y[30:23] == 8'd0) return x;
        d = x[30:23] - y[30:23];
        bx = {1'b1, y[22:0], 26'd0};
        bs = bx >> d;
        if ((bs << d) != bx) bs[0] = 1'b1;
        xm = {2'b01, x[22:0], 26'd0};
        s = (x[31] == y[31]) ? xm + {1'b0, bs} : xm - {1'b0, bs};
        if (s == 51'd0) return 32'd0;
        lz = '0;
        for (int i = 0; i < 51; i++) if (s[i]) lz = 6'(50 - i);
        n = 50'(s << lz);
        e = $signed({3'b000, x[30:23]}) + 11'sd1 - $signed({5'd0, lz});
        return fpack(x[31], e, n[49:27], n[26], |n[25:0]);
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return fadd(a, {~b[31], b[30:0]});
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic [49:0] num, den;
        logic [26:0] q;
        logic rem, s;
        logic signed [10:0] e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0) return {s, 31'd0};
        num = {1'b1, a[22:0], 26'd0};
        den = {26'd0, 1'b1, b[22:0]};
        q = 27'(num / den);
        rem = (num % den) != 50'd0;
        e = $signed({3'b000, a[30:23]}) - $signed({3'b000, b[30:23]}) + 11'sd127;
        if (q[26]) return fpack(s, e, q[25:3], q[2], |q[1:0] | rem);
        return fpack(s, e - 11'sd1, q[24:2], q[1], q[0] | rem);
    endfunction

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
    state_t state, next;
    logic [2:0][31:0] eye_r, ray_r, pos;
    logic [IDX_W-1:0] idx, best_idx;
    logic [CW-1:0] inflight;
    logic issue, ret, slab_hit, miss, best_hit;
    logic [31:0] lo, hi, t1, t2, tmin, tmax, slab_t, best_t;
    logic [SLAB_LAT-1:0] pv, ph;
    logic [31:0] pt [SLAB_LAT];
    logic [IDX_W-1:0] pi [SLAB_LAT];

    assign pos = {block_pos_z, block_pos_y, block_pos_x};
    assign issue = (state == STREAM) && block_valid_in;
    assign ret = pv[SLAB_LAT-1];

    always_comb begin
        ray_ready_out = state == IDLE;
        block_ready_out = state == STREAM;
        valid_out = state == DONE;
        next = (state == IDLE)   ? (ray_valid_in ? STREAM : IDLE) :
               (state == STREAM) ? ((block_valid_in && block_last_in) ? DRAIN : STREAM) :
               (state == DRAIN)  ? ((inflight == '0) ? DONE : DRAIN) : IDLE;
    end

    // A zero direction component never divides: the axis is a pure containment test.
    always_comb begin
        tmin = NEG_INF;
        tmax = POS_INF;
        miss = 1'b0;
        lo = '0;
        hi = '0;
        t1 = '0;
        t2 = '0;
        for (int a = 0; a < 3; a++) begin
            lo = fsub(fsub(pos[a], BLOCK_HALF), eye_r[a]);
            hi = fsub(fadd(pos[a], BLOCK_HALF), eye_r[a]);
            t1 = fdiv(lo, ray_r[a]);
            t2 = fdiv(hi, ray_r[a]);
            if (ray_r[a][30:23] == 8'd0) miss = miss | flt(32'd0, lo) | flt(hi, 32'd0);
            else begin
                tmin = fmax(tmin, fmin(t1, t2));
                tmax = fmin(tmax, fmax(t1, t2));
            end
        end
        slab_hit = !miss && !flt(tmax, tmin) && !flt(tmax, 32'd0);
        slab_t = flt(32'd0, tmin) ? tmin : 32'd0;
    end

    always_ff @(posedge clk_in) begin
        if (state == IDLE && ray_valid_in) begin
            eye_r <= {eye_z, eye_y, eye_x};
            ray_r <= {ray_z, ray_y, ray_x};
        end
        ph[0] <= slab_hit;
        pt[0] <= slab_t;
        pi[0] <= idx;
        for (int i = 1; i < SLAB_LAT; i++) begin
            ph[i] <= ph[i-1];
            pt[i] <= pt[i-1];
            pi[i] <= pi[i-1];
        end
    end

    // Results retire in index order, so a strict compare keeps the lower index on ties.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            inflight <= '0;
            idx <= '0;
            pv <= '0;
            best_hit <= 1'b0;
            best_t <= '0;
            best_idx <= '0;
            hit_out <= 1'b0;
            t_out <= '0;
            hit_idx_out <= '0;
            overflow_out <= 1'b0;
        end else begin
            state <= next;
            pv[0] <= issue;
            for (int i = 1; i < SLAB_LAT; i++) pv[i] <= pv[i-1];
            inflight <= inflight + CW'(issue) - CW'(ret);
            if (state == IDLE && ray_valid_in) begin
                idx <= '0;
                best_hit <= 1'b0;
                best_t <= '0;
                best_idx <= '0;
                overflow_out <= 1'b0;
            end
            if (issue) begin
                idx <= idx + IDX_W'(1);
                if (&idx) overflow_out <= 1'b1;
            end
            if (ret && ph[SLAB_LAT-1] && (!best_hit || flt(pt[SLAB_LAT-1], best_t))) begin
                best_hit <= 1'b1;
                best_t <= pt[SLAB_LAT-1];
                best_idx <= pi[SLAB_LAT-1];
            end
            if (state == DRAIN && next == DONE) begin
                hit_out <= best_hit;
                t_out <= best_t;
                hit_idx_out <= best_idx;
            end
        end
    end
endmodule
